// File: rtl/sd_pkg.sv
// sd_pkg: shared FSM states, 8-PAM mapping and leaf counter width for the sphere-decoder tracker.
package sd_pkg;
    localparam int LCW = 13;
    typedef enum logic [1:0] {SEARCH, FLUSH, REPORT} state_t;
    function automatic logic signed [4:0] pam(input logic [2:0] d);
        return $signed({1'b0, d, 1'b0}) - 5'sd7;
    endfunction
endpackage

// File: rtl/sd_sqdiff.sv
// sd_sqdiff: registered squared distance between one 8-PAM symbol and one received sample.
module sd_sqdiff
    import sd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic [2:0]              d,
    input  logic signed [WIDTH-1:0] y,
    output logic [2*WIDTH+3:0]      sq
);
    localparam int DW = WIDTH + 2;
    logic signed [DW-1:0] diff;
    logic signed [2*DW-1:0] p;
    assign diff = DW'(pam(d)) - DW'(y);
    assign p = (2*DW)'(diff) * (2*DW)'(diff);
    always_ff @(posedge clk) sq <= $unsigned(p);
endmodule

// File: rtl/dfs_best_tracker.sv
// dfs_best_tracker: keeps the minimum-metric leaf of a DFS enumeration and reports it after InDone.
module dfs_best_tracker
    import sd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int MW = 2*WIDTH+6
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [2:0]              InData0,
    input  logic [2:0]              InData1,
    input  logic [2:0]              InData2,
    input  logic [2:0]              InData3,
    input  logic [1:0]              InLvl,
    input  logic                    InDone,
    input  logic signed [WIDTH-1:0] Y0,
    input  logic signed [WIDTH-1:0] Y1,
    input  logic signed [WIDTH-1:0] Y2,
    input  logic signed [WIDTH-1:0] Y3,
    output logic [2:0]              BestData0,
    output logic [2:0]              BestData1,
    output logic [2:0]              BestData2,
    output logic [2:0]              BestData3,
    output logic [MW-1:0]           BestMetric,
    output logic                    BestValid,
    output logic [LCW-1:0]          LeafCount
);
    state_t state, state_nx;
    logic fcnt, leaf, v1;
    logic signed [WIDTH-1:0] yr [4];
    logic [3:0][2:0] din, d1, rd, bd;
    logic [3:0][2*WIDTH+3:0] sq;
    logic [MW-1:0] sum, best;
    logic [LCW-1:0] cnt;

    assign din = {InData3, InData2, InData1, InData0};
    assign leaf = (state == SEARCH) && (InLvl == 2'd0) && !InDone;
    assign sum = MW'(sq[0]) + MW'(sq[1]) + MW'(sq[2]) + MW'(sq[3]);
    assign {BestData3, BestData2, BestData1, BestData0} = bd;

    for (genvar g = 0; g < 4; g++) begin : g_sq
        sd_sqdiff #(.WIDTH(WIDTH)) u_sq (.clk(Clk), .d(din[g]), .y(yr[g]), .sq(sq[g]));
    end

    always_comb begin
        state_nx = (state == SEARCH && InDone) ? FLUSH :
                   (state == FLUSH && fcnt)    ? REPORT :
                   (state == REPORT)           ? SEARCH : state;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= SEARCH;
            fcnt       <= 1'b0;
            v1         <= 1'b0;
            BestValid  <= 1'b0;
            bd         <= '0;
            BestMetric <= '0;
            LeafCount  <= '0;
            best       <= '1;
            rd         <= '0;
            cnt        <= '0;
            yr         <= '{Y0, Y1, Y2, Y3};
        end else begin
            state     <= state_nx;
            fcnt      <= (state == FLUSH) && !fcnt;
            v1        <= leaf;
            d1        <= din;
            BestValid <= (state == FLUSH) && fcnt;
            if (state == FLUSH && fcnt) begin
                bd         <= rd;
                BestMetric <= best;
                LeafCount  <= cnt;
            end
            // leaving REPORT re-enters SEARCH: fresh running best and new samples
            if (state == REPORT) begin
                best <= '1;
                rd   <= '0;
                cnt  <= '0;
                yr   <= '{Y0, Y1, Y2, Y3};
            end else if (v1) begin
                cnt <= cnt + 1'b1;
                if (sum < best) begin
                    best <= sum;
                    rd   <= d1;
                end
            end
        end
    end
endmodule
